// File: rtl/fifo_param.sv
// fifo_param: single-clock FIFO with registered read data and sticky overflow/underflow flags.
// Underflow detection is compiled in only when FIFO_UNDERFLOW_DETECT_EN is defined.

module fifo_param #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_request,
  input  logic                  rd_request,
  input  logic                  clear_overflow_request,
  input  logic                  clear_underflow_request,
  input  logic [ADDR_WIDTH:0]   threshold,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   wr_index,
  output logic [ADDR_WIDTH:0]   rd_index,
  output logic [ADDR_WIDTH:0]   watermark
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  pop_ok;
  logic                  push_ok;

  assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  // Extra MSB on each pointer distinguishes full from empty when the addresses match.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_addr == rd_addr) && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign watermark   = wr_ptr - rd_ptr;
  assign almost_full = (watermark >= threshold);

  assign pop_ok  = rd_request && !empty;
  assign push_ok = wr_request && (!full || pop_ok);

  assign wr_index = wr_ptr;
  assign rd_index = rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        rd_data <= mem[rd_addr];
      end
    end
  end

  // Storage has no reset; a write coinciding with reset is suppressed.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_request && !push_ok) begin
      overflow <= 1'b1;
    end else if (clear_overflow_request) begin
      overflow <= 1'b0;
    end
  end

`ifdef FIFO_UNDERFLOW_DETECT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (rd_request && !pop_ok) begin
      underflow <= 1'b1;
    end else if (clear_underflow_request) begin
      underflow <= 1'b0;
    end
  end
`else
  logic unused_clear_underflow;
  assign unused_clear_underflow = clear_underflow_request;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed self-checking bench for fifo_param (default 9-bit x 16 configuration).
// Expected underflow behaviour follows FIFO_UNDERFLOW_DETECT_EN.

module tb_fifo_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] wr_data;
  logic       wr_request;
  logic       rd_request;
  logic       clear_overflow_request;
  logic       clear_underflow_request;
  logic [4:0] threshold;
  logic [8:0] rd_data;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       overflow;
  logic       underflow;
  logic [4:0] wr_index;
  logic [4:0] rd_index;
  logic [4:0] watermark;

  fifo_param #(.DATA_WIDTH(9), .ADDR_WIDTH(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .wr_data                 (wr_data),
    .wr_request              (wr_request),
    .rd_request              (rd_request),
    .clear_overflow_request  (clear_overflow_request),
    .clear_underflow_request (clear_underflow_request),
    .threshold               (threshold),
    .rd_data                 (rd_data),
    .empty                   (empty),
    .full                    (full),
    .almost_full             (almost_full),
    .overflow                (overflow),
    .underflow               (underflow),
    .wr_index                (wr_index),
    .rd_index                (rd_index),
    .watermark               (watermark)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [8:0] q[$];
  logic [8:0] exp_rd_data;
  logic [4:0] exp_wr;
  logic [4:0] exp_rd;
  logic       exp_ovf;
  logic       exp_udf;
  logic       saw_rd_wrap;
  logic       saw_wr_wrap;
  logic [4:0] prev_rd;
  logic [4:0] prev_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_rd_data = '0;
    exp_wr      = '0;
    exp_rd      = '0;
    exp_ovf     = 1'b0;
    exp_udf     = 1'b0;
  endtask

  // One clock with the given requests; model updated first, outputs compared #1 after the edge.
  task automatic step(input logic w, input logic [8:0] d, input logic r,
                      input logic co, input logic cu);
    logic pop_ok;
    logic push_ok;
    pop_ok  = r && (q.size() > 0);
    push_ok = w && ((q.size() < 16) || pop_ok);
    if (pop_ok) begin
      exp_rd_data = q.pop_front();
      exp_rd      = exp_rd + 5'd1;
    end
    if (push_ok) begin
      q.push_back(d);
      exp_wr = exp_wr + 5'd1;
    end
    if (w && !push_ok) exp_ovf = 1'b1;
    else if (co)       exp_ovf = 1'b0;
`ifdef FIFO_UNDERFLOW_DETECT_EN
    if (r && !pop_ok) exp_udf = 1'b1;
    else if (cu)      exp_udf = 1'b0;
`endif
    wr_request              = w;
    wr_data                 = d;
    rd_request              = r;
    clear_overflow_request  = co;
    clear_underflow_request = cu;
    @(posedge clk);
    #1;
    wr_request              = 1'b0;
    rd_request              = 1'b0;
    clear_overflow_request  = 1'b0;
    clear_underflow_request = 1'b0;
    check("rd_data",   32'(rd_data),   32'(exp_rd_data));
    check("watermark", 32'(watermark), 32'(q.size()));
    check("wr_index",  32'(wr_index),  32'(exp_wr));
    check("rd_index",  32'(rd_index),  32'(exp_rd));
    check("overflow",  32'(overflow),  32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_udf));
  endtask

  initial begin
    reset                   = 1'b1;
    wr_data                 = '0;
    wr_request              = 1'b0;
    rd_request              = 1'b0;
    clear_overflow_request  = 1'b0;
    clear_underflow_request = 1'b0;
    threshold               = 5'd12;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and threshold boundaries while empty
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_wm",    32'(watermark), 32'd0);
    check("rst_wr",    32'(wr_index), 32'd0);
    check("rst_rd",    32'(rd_index), 32'd0);
    check("rst_rdata", 32'(rd_data),  32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_udf",   32'(underflow), 32'd0);
    check("rst_af12",  32'(almost_full), 32'd0);
    threshold = 5'd0;
    #1 check("af_thr0_empty", 32'(almost_full), 32'd1);
    threshold = 5'd12;

    // Fill 0x001..0x010 with almost_full edge at 12
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 9'(i), 1'b0, 1'b0, 1'b0);
      if (i == 11) check("af_after_11", 32'(almost_full), 32'd0);
      if (i == 12) check("af_after_12", 32'(almost_full), 32'd1);
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_wm",   32'(watermark), 32'd16);
    check("fill_empty", 32'(empty), 32'd0);
    threshold = 5'd17;
    #1 check("af_thr17_full", 32'(almost_full), 32'd0);
    threshold = 5'd0;
    #1 check("af_thr0_full", 32'(almost_full), 32'd1);
    threshold = 5'd12;

    // Rejected push when full, then clear
    step(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_wm",  32'(watermark), 32'd16);
    check("ovf_wr",  32'(wr_index), 32'h10);
    step(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
    check("ovf_clr", 32'(overflow), 32'd0);

    // Drain in order; 0x1FF must never appear
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
      check("drain_data", 32'(rd_data), 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_wr", 32'(wr_index), 32'h10);
    check("drain_rd", 32'(rd_index), 32'h10);

    // Push and pop together on empty: push only
    step(1'b1, 9'h055, 1'b1, 1'b0, 1'b0);
    check("sim_empty_wm", 32'(watermark), 32'd1);
    check("sim_empty_rdata_hold", 32'(rd_data), 32'h010);
`ifdef FIFO_UNDERFLOW_DETECT_EN
    check("sim_empty_udf", 32'(underflow), 32'd1);
`else
    check("sim_empty_udf", 32'(underflow), 32'd0);
`endif
    step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
    check("udf_clr", 32'(underflow), 32'd0);
    step(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
    check("pop_055", 32'(rd_data), 32'h055);

    // Almost-full threshold crossing in both directions
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 9'(9'h100 + i), 1'b0, 1'b0, 1'b0);
      if (i == 10) check("af_push11", 32'(almost_full), 32'd0);
    end
    check("af_push12", 32'(almost_full), 32'd1);
    step(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
    check("af_pop1", 32'(almost_full), 32'd0);
    check("af_pop_data", 32'(rd_data), 32'h100);

    // Push and pop together when full: both accepted
    for (int i = 12; i < 17; i++) step(1'b1, 9'(9'h100 + i), 1'b0, 1'b0, 1'b0);
    check("sim_full_pre", 32'(full), 32'd1);
    step(1'b1, 9'h0AA, 1'b1, 1'b0, 1'b0);
    check("sim_full_wm",   32'(watermark), 32'd16);
    check("sim_full_ovf",  32'(overflow), 32'd0);
    check("sim_full_data", 32'(rd_data), 32'h101);
    while (q.size() > 0) step(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
    check("sim_full_last", 32'(rd_data), 32'h0AA);

    // Wrap-around: 40 push/pop pairs
    saw_rd_wrap = 1'b0;
    saw_wr_wrap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prev_wr = wr_index;
      step(1'b1, 9'(9'h0C0 + i * 3), 1'b0, 1'b0, 1'b0);
      if (prev_wr == 5'h1F && wr_index == 5'h00) saw_wr_wrap = 1'b1;
      prev_rd = rd_index;
      step(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
      if (prev_rd == 5'h1F && rd_index == 5'h00) saw_rd_wrap = 1'b1;
      check("wrap_data", 32'(rd_data), 32'(9'(9'h0C0 + i * 3)));
    end
    check("wrap_wr_seen", 32'(saw_wr_wrap), 32'd1);
    check("wrap_rd_seen", 32'(saw_rd_wrap), 32'd1);
    check("wrap_empty", 32'(empty), 32'd1);

    // Reset mid-operation with level 7 and overflow set
    for (int i = 0; i < 17; i++) step(1'b1, 9'(9'h040 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
    check("mid_wm",  32'(watermark), 32'd7);
    check("mid_ovf", 32'(overflow), 32'd1);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("arst_wm",    32'(watermark), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_full",  32'(full), 32'd0);
    check("arst_ovf",   32'(overflow), 32'd0);
    check("arst_udf",   32'(underflow), 32'd0);
    check("arst_rdata", 32'(rd_data), 32'd0);
    check("arst_wr",    32'(wr_index), 32'd0);
    check("arst_rd",    32'(rd_index), 32'd0);
    wr_request = 1'b1;
    wr_data    = 9'h1AB;
    rd_request = 1'b1;
    @(posedge clk);
    #1;
    wr_request = 1'b0;
    rd_request = 1'b0;
    check("rst_cycle_wm", 32'(watermark), 32'd0);
    check("rst_cycle_wr", 32'(wr_index), 32'd0);
    reset = 1'b0;
    step(1'b1, 9'h123, 1'b0, 1'b0, 1'b0);
    step(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
    check("post_rst_data", 32'(rd_data), 32'h123);
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
